// File: rtl/mantissa_normalizer.sv
// Post-add/subtract mantissa normalizer: leading-zero count, log shift, exponent fix-up, 2-stage elastic pipe.
// Build option: define NORM_DENORM_EN for gradual underflow (default is flush-to-zero).
module mantissa_normalizer #(
    parameter int MW = 23,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_sign_i,
    input  logic          in_carry_i,
    input  logic [MW:0]   in_mant_i,
    input  logic [EW-1:0] in_exp_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_sign_o,
    output logic [EW-1:0] out_exp_o,
    output logic [MW-1:0] out_mant_o,
    output logic          out_zero_o,
    output logic          out_ovf_o,
    output logic          out_unf_o
);
    localparam int LZW = $clog2(MW + 2);  // lz spans 0..MW+1
    localparam int CW  = EW + LZW;
    localparam logic [EW-1:0] EXP_MAX = '1;

    logic           s1_valid_q, s2_valid_q;
    logic           s1_sign_q, s1_carry_q, s1_zero_q;
    logic [MW:0]    s1_mant_q;
    logic [EW-1:0]  s1_exp_q;
    logic [LZW-1:0] s1_lz_q, lz_d;

    logic           sign_d, zero_d, ovf_d, unf_d;
    logic [EW-1:0]  exp_d, exp_inc;
    logic [MW-1:0]  mant_d;
    logic           sign_q, zero_q, ovf_q, unf_q;
    logic [EW-1:0]  exp_q;
    logic [MW-1:0]  mant_q;

    logic s2_load, in_fire, underflow;
    logic [CW-1:0]  exp_ext, lz_ext;
    logic [LZW-1:0] shamt;
    logic [LZW:0][MW:0] shl;

    assign s2_load    = ~s2_valid_q | out_ready_i;
    assign in_ready_o = ~s1_valid_q | s2_load;
    assign in_fire    = in_valid_i & in_ready_o;

    // Highest set bit wins: later loop iterations overwrite earlier ones.
    always_comb begin
        lz_d = LZW'(MW + 1);
        for (int i = 0; i <= MW; i++) begin
            if (in_mant_i[i]) lz_d = LZW'(MW - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_lz_q    <= '0;
        end else begin
            if (in_ready_o) s1_valid_q <= in_valid_i;
            if (in_fire) begin
                s1_sign_q  <= in_sign_i;
                s1_carry_q <= in_carry_i;
                s1_zero_q  <= (in_mant_i == '0) & ~in_carry_i;
                s1_mant_q  <= in_mant_i;
                s1_exp_q   <= in_exp_i;
                s1_lz_q    <= lz_d;
            end
        end
    end

    assign exp_ext   = CW'(s1_exp_q);
    assign lz_ext    = CW'(s1_lz_q);
    assign exp_inc   = s1_exp_q + EW'(1);
    assign underflow = (lz_ext >= exp_ext);

`ifdef NORM_DENORM_EN
    // Denormal result keeps exponent 0, so only exp-1 positions can be recovered.
    assign shamt = !underflow ? s1_lz_q :
                   (s1_exp_q == '0) ? '0 : LZW'(exp_ext - CW'(1));
`else
    assign shamt = s1_lz_q;
`endif

    assign shl[0] = s1_mant_q;
    for (genvar k = 0; k < LZW; k++) begin : g_shl
        assign shl[k+1] = shamt[k] ? (shl[k] << (2 ** k)) : shl[k];
    end

    always_comb begin
        sign_d = s1_sign_q;
        exp_d  = '0;
        mant_d = '0;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (s1_exp_q == EXP_MAX) begin
            exp_d = EXP_MAX;
            ovf_d = 1'b1;
        end else if (s1_carry_q) begin
            exp_d = exp_inc;
            if (exp_inc == EXP_MAX) ovf_d = 1'b1;
            else                    mant_d = s1_mant_q[MW:1];
        end else if (s1_zero_q) begin
            zero_d = 1'b1;
        end else if (!underflow) begin
            exp_d  = EW'(exp_ext - lz_ext);
            mant_d = shl[LZW][MW-1:0];
        end else begin
            unf_d = 1'b1;
`ifdef NORM_DENORM_EN
            mant_d = shl[LZW][MW-1:0];
            zero_d = (shl[LZW][MW-1:0] == '0);
`else
            zero_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_q <= sign_d;
                exp_q  <= exp_d;
                mant_q <= mant_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_sign_o  = sign_q;
    assign out_exp_o   = exp_q;
    assign out_mant_o  = mant_q;
    assign out_zero_o  = zero_q;
    assign out_ovf_o   = ovf_q;
    assign out_unf_o   = unf_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Bench for mantissa_normalizer (MW=23, EW=8): directed cases, stall, reset, and random traffic vs a reference model.
module tb_mantissa_normalizer;
    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic        z;
        logic        o;
        logic        u;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_sign = 1'b0, in_carry = 1'b0;
    logic [23:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid, out_ready = 1'b1, out_sign, out_zero, out_ovf, out_unf;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;

    int   tests = 0;
    int   fails = 0;
    res_t q[$];
    res_t nxt;

    always #5 clk = ~clk;

    mantissa_normalizer #(.MW(23), .EW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sign_i(in_sign),
        .in_carry_i(in_carry), .in_mant_i(in_mant), .in_exp_i(in_exp),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sign_o(out_sign),
        .out_exp_o(out_exp), .out_mant_o(out_mant), .out_zero_o(out_zero),
        .out_ovf_o(out_ovf), .out_unf_o(out_unf)
    );

    function automatic res_t model(logic s, logic c, logic [23:0] m, logic [7:0] e);
        res_t   r;
        int     ei, lz;
        longint v;
        r = '0;
        r.s = s;
        ei = int'(e);
        if (ei == 255) begin
            r.e = 8'hFF; r.o = 1'b1;
        end else if (c) begin
            if (ei + 1 == 255) begin
                r.e = 8'hFF; r.o = 1'b1;
            end else begin
                r.e = 8'(ei + 1);
                v = (longint'(m) + (longint'(1) << 24)) >> 1;
                r.m = v[22:0];
            end
        end else if (m == 24'd0) begin
            r.z = 1'b1;
        end else begin
            lz = 0;
            v = longint'(m);
            while (v < (longint'(1) << 23)) begin
                v = v * 2;
                lz++;
            end
            if (lz < ei) begin
                r.e = 8'(ei - lz);
                r.m = v[22:0];
            end else begin
                r.u = 1'b1;
`ifdef NORM_DENORM_EN
                v = longint'(m) << ((ei == 0) ? 0 : ei - 1);
                r.m = v[22:0];
                r.z = (r.m == 23'd0);
`else
                r.z = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One cycle: sample just after the falling edge, score outputs, record transfers, advance.
    task automatic tick(output bit acc);
        bit inf, outf;
        res_t got;
        #1;
        inf  = in_valid & in_ready;
        outf = out_valid & out_ready;
        got  = '{out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf};
        if (out_valid) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_out got=%h", got);
            end
            if (q.size() > 0) check("result", 64'(got), 64'(q[0]));
        end
        if (outf && q.size() > 0) void'(q.pop_front());
        if (inf) q.push_back(nxt);
        acc = inf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic s, logic c, logic [23:0] m, logic [7:0] e, res_t ex);
        in_valid = 1'b1; in_sign = s; in_carry = c; in_mant = m; in_exp = e;
        nxt = ex;
    endtask

    task automatic send(logic s, logic c, logic [23:0] m, logic [7:0] e, res_t ex);
        bit acc;
        int n;
        drive(s, c, m, e, ex);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        bit acc;
        for (int c = 0; c < 100 && q.size() > 0; c++) tick(acc);
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic rand_in(output logic s, output logic c, output logic [23:0] m, output logic [7:0] e);
        s = 1'($urandom);
        c = ($urandom_range(0, 3) == 0);
        m = 24'($urandom) >> $urandom_range(0, 24);
        case ($urandom_range(0, 5))
            0: e = 8'($urandom_range(0, 30));
            1: e = 8'hFF;
            2: e = 8'hFE;
            3: e = 8'($urandom_range(0, 3));
            default: e = 8'($urandom);
        endcase
    endtask

    initial begin
        bit acc;
        int k;
        logic rs, rc;
        logic [23:0] rm;
        logic [7:0] re;
        res_t ex4;

        // reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_payload", 64'({out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // case 1 with explicit 2-cycle latency
        send(1'b0, 1'b0, 24'h800000, 8'd127, res_t'{1'b0, 8'd127, 23'h0, 1'b0, 1'b0, 1'b0});
        check("lat_c1", 64'(out_valid), 64'(0));
        tick(acc);
        check("lat_c2", 64'(out_valid), 64'(1));
        drain();

        // cases 2-4
        send(1'b1, 1'b0, 24'h000001, 8'd100, res_t'{1'b1, 8'd77, 23'h0, 1'b0, 1'b0, 1'b0});
        send(1'b0, 1'b1, 24'h800001, 8'd127, res_t'{1'b0, 8'd128, 23'h400000, 1'b0, 1'b0, 1'b0});
        send(1'b0, 1'b1, 24'h123456, 8'd254, res_t'{1'b0, 8'd255, 23'h0, 1'b0, 1'b1, 1'b0});
        send(1'b0, 1'b0, 24'h5A5A5A, 8'd255, res_t'{1'b0, 8'd255, 23'h0, 1'b0, 1'b1, 1'b0});
        send(1'b0, 1'b0, 24'h000000, 8'd40, res_t'{1'b0, 8'd0, 23'h0, 1'b1, 1'b0, 1'b0});
`ifdef NORM_DENORM_EN
        ex4 = res_t'{1'b0, 8'd0, 23'h020000, 1'b0, 1'b0, 1'b1};
`else
        ex4 = res_t'{1'b0, 8'd0, 23'h0, 1'b1, 1'b0, 1'b1};
`endif
        send(1'b0, 1'b0, 24'h000100, 8'd10, ex4);
        drain();

        // case 5: four back-to-back inputs, output stalled for 3 cycles
        k = 0;
        for (int c = 0; c < 30 && (k < 4 || q.size() > 0); c++) begin
            out_ready = (c >= 3);
            if (k < 4) begin
                rm = 24'h400000 >> k;
                drive(1'b0, 1'b0, rm, 8'(50 + k), model(1'b0, 1'b0, rm, 8'(50 + k)));
            end else in_valid = 1'b0;
            if (c == 2) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_out_valid", 64'(out_valid), 64'(1));
            end
            tick(acc);
            if (acc) k++;
        end
        in_valid = 1'b0;
        check("stall_all_sent", 64'(k), 64'(4));
        drain();

        // case 6: reset with two results in flight
        out_ready = 1'b0;
        send(1'b0, 1'b0, 24'h0F0000, 8'd90, model(1'b0, 1'b0, 24'h0F0000, 8'd90));
        send(1'b1, 1'b0, 24'h00F000, 8'd90, model(1'b1, 1'b0, 24'h00F000, 8'd90));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_payload", 64'({out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}), 64'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick(acc);
        send(1'b0, 1'b0, 24'h000300, 8'd60, model(1'b0, 1'b0, 24'h000300, 8'd60));
        drain();

        // random traffic with random backpressure
        k = 0;
        for (int c = 0; c < 3000 && k < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    rand_in(rs, rc, rm, re);
                    drive(rs, rc, rm, re, model(rs, rc, rm, re));
                end
            end
            tick(acc);
            if (acc) begin
                k++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_count", 64'(k), 64'(400));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
